// File: rtl/trace_dump_unit.sv
// trace_dump_unit: counts cycles/stalls/flushes and streams a 45-word snapshot frame
// (header, counters, PC, GPRs, low data memory) over a 32-bit valid/ready link.
module trace_dump_unit #(
   parameter int CNT_W         = 32,
   parameter int NUM_REGS      = 32,
   parameter int NUM_MEM_WORDS = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [31:0]      pc_i,
   input  logic             dump_req_i,
   output logic [4:0]       reg_addr_o,
   input  logic [31:0]      reg_data_i,
   output logic [31:0]      mem_addr_o,
   input  logic [31:0]      mem_data_i,
   output logic             tx_valid_o,
   output logic [31:0]      tx_data_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   localparam int REG_LO = 5;
   localparam int MEM_LO = REG_LO + NUM_REGS;
   localparam int LAST   = MEM_LO + NUM_MEM_WORDS - 1;

   typedef enum logic [2:0] {IDLE, HDR, CNT, REG, MEM} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0] cyc, stl, fls, cyc_nx, stl_nx, fls_nx;
   logic [CNT_W-1:0] snap_cyc, snap_stl, snap_fls;
   logic [31:0]      snap_pc, nxt_data, mem_hold;
   logic [15:0]      seq;
   logic [7:0]       idx, nidx, reg_off, mem_off;
   logic [4:0]       reg_hold;
   logic             xfer, accept, in_reg, in_mem;

   assign cycle_cnt_o = cyc;
   assign stall_cnt_o = stl;
   assign flush_cnt_o = fls;
   assign tx_valid_o  = state != IDLE;
   assign busy_o      = state != IDLE;
   assign xfer        = tx_valid_o & tx_ready_i;
   assign accept      = state == IDLE && dump_req_i;

   // Saturating counters; snapshots take these next values so the request edge is included.
   assign cyc_nx = (start_i && !(&cyc)) ? cyc + CNT_W'(1) : cyc;
   assign stl_nx = (start_i && stall_i && !(&stl)) ? stl + CNT_W'(1) : stl;
   assign fls_nx = (start_i && flush_i && !(&fls)) ? fls + CNT_W'(1) : fls;

   // Read ports address the word loaded at the next transfer; elsewhere they keep their last value.
   always_comb begin
      nidx       = idx + 8'd1;
      reg_off    = nidx - 8'(REG_LO);
      mem_off    = nidx - 8'(MEM_LO);
      in_reg     = nidx >= 8'(REG_LO) && nidx < 8'(MEM_LO);
      in_mem     = nidx >= 8'(MEM_LO) && nidx <= 8'(LAST);
      reg_addr_o = in_reg ? reg_off[4:0] : reg_hold;
      mem_addr_o = in_mem ? {22'd0, mem_off, 2'b00} : mem_hold;
      nxt_data   = nidx == 8'd1 ? 32'(snap_cyc) :
                   nidx == 8'd2 ? 32'(snap_stl) :
                   nidx == 8'd3 ? 32'(snap_fls) :
                   nidx == 8'd4 ? snap_pc :
                   in_reg       ? reg_data_i :
                   in_mem       ? mem_data_i : 32'd0;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = dump_req_i ? HDR : IDLE;
         HDR:     state_nx = xfer ? CNT : HDR;
         CNT:     state_nx = (xfer && idx == 8'd4) ? REG : CNT;
         REG:     state_nx = (xfer && idx == 8'(MEM_LO - 1)) ? MEM : REG;
         MEM:     state_nx = (xfer && idx == 8'(LAST)) ? IDLE : MEM;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cyc       <= '0;
         stl       <= '0;
         fls       <= '0;
         snap_cyc  <= '0;
         snap_stl  <= '0;
         snap_fls  <= '0;
         snap_pc   <= '0;
         seq       <= '0;
         idx       <= '0;
         tx_data_o <= '0;
         reg_hold  <= '0;
         mem_hold  <= '0;
      end else begin
         state    <= state_nx;
         cyc      <= cyc_nx;
         stl      <= stl_nx;
         fls      <= fls_nx;
         reg_hold <= reg_addr_o;
         mem_hold <= mem_addr_o;
         if (accept) begin
            tx_data_o <= {16'hC0DE, seq};
            seq       <= seq + 16'd1;
            idx       <= '0;
            snap_cyc  <= cyc_nx;
            snap_stl  <= stl_nx;
            snap_fls  <= fls_nx;
            snap_pc   <= pc_i;
         end else if (xfer) begin
            tx_data_o <= nxt_data;
            idx       <= nidx;
         end
      end
   end
endmodule
